xor_parity_pipe: RTL

//  Parametrised, pipelined XOR-parity generator. Each of OUT_W output channels is the

---
 rtl/xor_parity_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/xor_parity_pipe.sv
// Pipelined per-channel XOR parity behind a valid/ready handshake.
// Define XOR_PARITY_ACC_EN to accumulate parity across beats, closing each packet on in_last.
module xor_parity_pipe #(
  parameter int IN_W        = 20,
  parameter int OUT_W       = 10,
  parameter int PIPE_STAGES = 2,
  parameter logic [OUT_W*IN_W-1:0] TAP_MASK =
    {120'h0, 20'h00060, 20'h00060, 20'h00063, 20'h00063}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam int LAST = PIPE_STAGES - 1;

  logic             adv;
  logic [OUT_W-1:0] par;
  logic             ent_valid_d;
  logic             ent_last_d;
  logic [OUT_W-1:0] ent_data_d;

  logic             stg_valid_q [PIPE_STAGES];
  logic             stg_last_q  [PIPE_STAGES];
  logic [OUT_W-1:0] stg_data_q  [PIPE_STAGES];

  for (genvar k = 0; k < OUT_W; k++) begin : g_par
    assign par[k] = ^(in_data & TAP_MASK[k*IN_W +: IN_W]);
  end

  // A stall anywhere freezes the whole pipe; bubbles are never collapsed.
  assign adv      = !stg_valid_q[LAST] || out_ready;
  assign in_ready = adv;

`ifdef XOR_PARITY_ACC_EN
  logic             accept;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;

  assign accept = in_valid && adv;

  always_comb begin
    acc_d       = acc_q;
    ent_valid_d = in_valid && in_last;
    ent_data_d  = acc_q ^ par;
    ent_last_d  = 1'b1;
    if (accept) begin
      acc_d = in_last ? '0 : (acc_q ^ par);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = in_last;

  always_comb begin
    ent_valid_d = in_valid;
    ent_data_d  = par;
    ent_last_d  = 1'b0;
  end
`endif

  // Data only moves with a valid beat, so out_data stays put while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        stg_valid_q[i] <= 1'b0;
        stg_last_q[i]  <= 1'b0;
        stg_data_q[i]  <= '0;
      end
    end else if (adv) begin
      stg_valid_q[0] <= ent_valid_d;
      if (ent_valid_d) begin
        stg_data_q[0] <= ent_data_d;
        stg_last_q[0] <= ent_last_d;
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        stg_valid_q[i] <= stg_valid_q[i-1];
        if (stg_valid_q[i-1]) begin
          stg_data_q[i] <= stg_data_q[i-1];
          stg_last_q[i] <= stg_last_q[i-1];
        end
      end
    end
  end

  assign out_valid = stg_valid_q[LAST];
  assign out_data  = stg_data_q[LAST];
  assign out_last  = stg_last_q[LAST];

endmodule
